// File: rtl/fx3_out_path_pkg.sv
// Shared FX3 definitions: out-path state encoding and default DMA geometry.
package fx3_out_path_pkg;

  localparam int FX3_DMA_BUF_WORDS = 256;
  localparam int FX3_SIZE_WIDTH    = 24;
  localparam int FX3_DATA_WIDTH    = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_WRITE    = 3'd2,
    ST_BUF_DONE = 3'd3,
    ST_FINISH   = 3'd4
  } fx3_out_state_t;

endpackage

// File: rtl/fx3_out_path_if.sv
// Bus-controller, ping-pong FIFO and GPIF signals of the FX3 out path.
interface fx3_out_path_if
  import fx3_out_path_pkg::*;
#(
  parameter int SIZE_WIDTH = FX3_SIZE_WIDTH
) ();

  logic                      o_ready;
  logic                      i_enable;
  logic                      o_busy;
  logic                      o_finished;
  logic                      i_dma_buf_ready;
  logic                      o_dma_buf_finished;
  logic                      i_rd_rdy;
  logic                      o_rd_act;
  logic [SIZE_WIDTH-1:0]     i_rd_size;
  logic                      o_rd_stb;
  logic [FX3_DATA_WIDTH-1:0] i_rd_data;
  logic [FX3_DATA_WIDTH-1:0] o_data;
  logic                      o_write;
  logic                      o_packet_end;

  modport master (
    output o_ready, o_busy, o_finished, o_dma_buf_finished, o_rd_act, o_rd_stb,
           o_data, o_write, o_packet_end,
    input  i_enable, i_dma_buf_ready, i_rd_rdy, i_rd_size, i_rd_data
  );

  modport slave (
    input  o_ready, o_busy, o_finished, o_dma_buf_finished, o_rd_act, o_rd_stb,
           o_data, o_write, o_packet_end,
    output i_enable, i_dma_buf_ready, i_rd_rdy, i_rd_size, i_rd_data
  );

endinterface

// File: rtl/fx3_out_path.sv
// Moves one ping-pong FIFO block into FX3 DMA buffers over the GPIF write port.
//
// state    | meaning
// IDLE     | no transfer; o_ready when a FIFO block waits
// WAIT_BUF | block owned, waiting for a free FX3 DMA buffer
// WRITE    | strobing FIFO words into the current DMA buffer
// BUF_DONE | buffer filled or closed, waiting for the socket to drop ready
// FINISH   | block drained, o_finished held until the grant is removed
module fx3_out_path
  import fx3_out_path_pkg::*;
#(
  parameter int DMA_BUF_WORDS = FX3_DMA_BUF_WORDS,
  parameter int SIZE_WIDTH    = FX3_SIZE_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  fx3_out_path_if.master bus
);

  localparam int                    BC_W     = $clog2(DMA_BUF_WORDS) + 1;
  localparam logic [BC_W-1:0]       BUF_FULL = BC_W'(DMA_BUF_WORDS);
  localparam logic [BC_W-1:0]       BUF_LAST = BC_W'(DMA_BUF_WORDS - 1);
  localparam logic [BC_W-1:0]       BC_ONE   = BC_W'(1);
  localparam logic [SIZE_WIDTH-1:0] ONE_WORD = SIZE_WIDTH'(1);

  fx3_out_state_t            state;
  logic [SIZE_WIDTH-1:0]     remaining;
  logic [BC_W-1:0]           buf_count;
  logic                      rd_act;
  logic                      busy;
  logic                      finished;
  logic                      buf_finished;
  logic                      write;
  logic                      packet_end;
  logic [FX3_DATA_WIDTH-1:0] data;
  logic                      stb;
  logic                      last_word;
  logic                      last_in_buf;
  logic                      in_xfer;

  // The strobe is combinational so a dropped grant or reset stops the pop in the same cycle.
  assign stb = !rst && bus.i_enable && (state == ST_WRITE) &&
               (remaining != '0) && (buf_count < BUF_FULL);
  assign last_word   = (remaining == ONE_WORD);
  assign last_in_buf = (buf_count == BUF_LAST);
  assign in_xfer     = (state == ST_WAIT_BUF) || (state == ST_WRITE) || (state == ST_BUF_DONE);

  assign bus.o_ready            = bus.i_rd_rdy && !rd_act && (state == ST_IDLE);
  assign bus.o_busy             = busy;
  assign bus.o_finished         = finished;
  assign bus.o_dma_buf_finished = buf_finished;
  assign bus.o_rd_act           = rd_act;
  assign bus.o_rd_stb           = stb;
  assign bus.o_data             = data;
  assign bus.o_write            = write;
  assign bus.o_packet_end       = packet_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      buf_count    <= '0;
      rd_act       <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      buf_finished <= 1'b0;
      write        <= 1'b0;
      packet_end   <= 1'b0;
      data         <= '0;
    end else begin
      write        <= 1'b0;
      packet_end   <= 1'b0;
      buf_finished <= 1'b0;
      if (!bus.i_enable && in_xfer) begin
        rd_act <= 1'b0;
        busy   <= 1'b0;
        state  <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.i_enable && bus.i_rd_rdy) begin
              rd_act    <= 1'b1;
              busy      <= 1'b1;
              remaining <= bus.i_rd_size;
              state     <= (bus.i_rd_size == '0) ? ST_FINISH : ST_WAIT_BUF;
            end
          end
          ST_WAIT_BUF: begin
            if (bus.i_dma_buf_ready) begin
              buf_count <= '0;
              state     <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (stb) begin
              remaining  <= remaining - ONE_WORD;
              buf_count  <= buf_count + BC_ONE;
              data       <= bus.i_rd_data;
              write      <= 1'b1;
              // A buffer that fills exactly on the last word is closed by size, not by a short packet.
              packet_end <= last_word && !last_in_buf;
              if (last_word || last_in_buf) begin
                buf_finished <= 1'b1;
                state        <= ST_BUF_DONE;
              end
            end
          end
          ST_BUF_DONE: begin
            if (!bus.i_dma_buf_ready) begin
              if (remaining != '0) begin
                state <= ST_WAIT_BUF;
              end else begin
                rd_act <= 1'b0;
                state  <= ST_FINISH;
              end
            end
          end
          ST_FINISH: begin
            busy   <= 1'b0;
            rd_act <= 1'b0;
            if (bus.i_enable) begin
              finished <= 1'b1;
            end else begin
              finished <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
